adc_avg_fifo: RTL
=================

Name: adc_avg_fifo

Overview:
- Sits directly downstream of the ADC interface top level and consumes its 10-bit latched conversion result and its done strobe.
- Averages 2^LOG2N consecutive samples from the same channel into one 10-bit result, tagged with the 3-bit channel select.
- Buffers results in a small FIFO with a valid/ready read port for the consumer (display, UART or processor).

Parameters:
- LOG2N, 2, log2 of samples per average (0 = pass-through, max 6)
- DEPTH, 4, FIFO entries (power of 2, ≥2)

Ports:
- clk  input  1  system clock, same clock that drives the ADC clock divider
- rst  input  1  asynchronous active-high reset
- enable  input  1  accept samples when high
- chan  input  3  channel select {I3,I2,I1}, stable during a conversion
- done  input  1  conversion-complete level from ADC interface
- data_in  input  10  latched conversion result, stable while done is high
- rd_ready  input  1  consumer accepts head entry
- clr_ovf  input  1  clears overflow flag
- rd_valid  output  1  FIFO non-empty
- avg_out  output  10  head entry average (show-ahead)
- avg_chan  output  3  head entry channel tag
- level  output  clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky: a result was dropped

Behaviour:
- Reset (async, rst=1): acc=0, count=0, done_q=0, FIFO pointers=0, rd_valid=0, avg_out=0, avg_chan=0, level=0, overflow=0. Reset mid-accumulation discards the partial sum.
- Sample detect: done registered into done_q each clk; sample_ev = done & ~done_q & enable. One event per done rising edge regardless of pulse width. done held high across many cycles gives one sample.
- Accumulator: width 10+LOG2N, count width LOG2N+1.
  - On sample_ev with count==0: acc=data_in, acc_chan=chan, count=1.
  - On sample_ev with count>0 and chan==acc_chan: acc+=data_in, count+=1.
  - On sample_ev with chan!=acc_chan: discard the partial sum. Restart with acc=data_in, acc_chan=chan, count=1.
- Completion: when sample_ev brings count to 2^LOG2N:
  - Push {acc_chan, (acc+data_in)>>LOG2N}, truncating (floor).
  - Set acc=0, count=0 on the same edge.
  - For LOG2N=0, every sample is pushed directly.
- Latency: done sampled high at clk edge E → accumulate/push at the same edge E (done_q still 0) → rd_valid=1, avg_out valid after edge E.
- enable low: sample_ev suppressed. acc and count cleared synchronously. FIFO contents, reads and overflow are unaffected.
- FIFO behaviour:
  - Pop occurs when rd_valid & rd_ready.
  - Push into a full FIFO without a simultaneous pop: result dropped, overflow=1.
  - Full with push and pop in the same cycle: both succeed, level unchanged, no overflow.
  - Empty with push and rd_ready=1 in the same cycle: no pop (rd_valid was 0), entry stored, level=1.
  - Pointers wrap modulo DEPTH. level = entries stored, 0..DEPTH.
- overflow: sticky until rst or clr_ovf. If clr_ovf and a new drop occur in the same cycle, the drop wins (overflow=1).
- avg_out and avg_chan are combinational from the head entry. They hold their last value when empty and read 0 after reset.

Decomposition:
- Shared package/header constants: ADC_W=10, CH_W=3.
- One sub-module: sync_fifo, parameters WIDTH=13 and DEPTH, with ports wr_en, wr_data, rd_en, rd_data, full, empty, level.
- Edge detect, accumulator and overflow logic live in adc_avg_fifo.

Test Plan:
- LOG2N=2, chan=3'b001, samples 100,101,102,103 (one done pulse each) → one entry avg_out=101, avg_chan=001, level=1 after the 4th done edge.
- LOG2N=2, four samples of 1023 → avg_out=1023, no width overflow. Samples 0,0,0,3 → avg_out=0 (floor).
- Channel switch: two samples on chan 001, then four on chan 010 of value 40 → exactly one entry {010,40}, nothing from chan 001.
- done held high for 20 clk per conversion, four conversions → exactly one entry (no repeated accumulation).
- rd_ready=0, DEPTH=4, produce 5 averages → level=4, overflow=1, first four entries read back in order. Then clr_ovf → overflow=0.
- Full FIFO with rd_ready=1 coinciding with a push → level stays 4, overflow stays 0, order preserved.
- rst asserted after 3 of 4 samples, then 4 fresh samples of 8 → single entry avg_out=8.

Source files
------------

// File: rtl/adc_avg_fifo_pkg.sv
// adc_avg_fifo_pkg: shared widths and the FIFO entry layout for the ADC averaging FIFO.
package adc_avg_fifo_pkg;
    localparam int ADC_W   = 10;
    localparam int CH_W    = 3;
    localparam int ENTRY_W = ADC_W + CH_W;

    typedef struct packed {
        logic [CH_W-1:0]  chan;
        logic [ADC_W-1:0] avg;
    } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; head output holds the last popped entry while empty.
module sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_rd   = rd_en & ~empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? last : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            last   <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                last   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/adc_avg_fifo.sv
// adc_avg_fifo: averages 2^LOG2N same-channel ADC samples per done edge and queues
// channel-tagged results in a small valid/ready FIFO with a sticky overflow flag.
module adc_avg_fifo
    import adc_avg_fifo_pkg::*;
#(
    parameter int LOG2N = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CH_W-1:0]          chan,
    input  logic                     done,
    input  logic [ADC_W-1:0]         data_in,
    input  logic                     rd_ready,
    input  logic                     clr_ovf,
    output logic                     rd_valid,
    output logic [ADC_W-1:0]         avg_out,
    output logic [CH_W-1:0]          avg_chan,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = ADC_W + LOG2N;
    localparam int CW = LOG2N + 1;
    localparam logic [CW-1:0] N_CNT = CW'(1 << LOG2N);

    logic            done_q;
    logic            sample_ev;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   sum;
    logic [CW-1:0]   count;
    logic [CW-1:0]   next_cnt;
    logic [CH_W-1:0] acc_chan;
    logic            restart;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    entry_t          wr_entry;
    entry_t          head;

    assign sample_ev = done & ~done_q & enable;

    always_comb begin
        restart  = (count == '0) || (chan != acc_chan);
        sum      = (restart ? '0 : acc) + AW'(data_in);
        next_cnt = restart ? CW'(1) : count + 1'b1;
        push     = sample_ev && (next_cnt == N_CNT);
        wr_entry = '{chan: chan, avg: ADC_W'(sum >> LOG2N)};
    end

    assign pop      = rd_valid & rd_ready;
    assign rd_valid = ~empty;
    assign avg_out  = head.avg;
    assign avg_chan = head.chan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            acc      <= '0;
            count    <= '0;
            acc_chan <= '0;
            overflow <= 1'b0;
        end else begin
            done_q <= done;
            if (!enable) begin
                acc   <= '0;
                count <= '0;
            end else if (sample_ev) begin
                acc_chan <= chan;
                acc      <= push ? '0 : sum;
                count    <= push ? '0 : next_cnt;
            end
            // A drop in the same cycle as clr_ovf leaves the flag set.
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (rd_ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );
endmodule
